// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter (reverse double dabble).
// A packed BCD operand is shifted right one bit per cycle into a binary field;
// after each shift every BCD digit >= 8 has 3 subtracted. After BIN_W steps the
// binary field holds the exact value and the BCD field has drained to zero.
module bcd_to_bin_seq #(
    parameter int unsigned DIGITS = 2,
    parameter int unsigned BIN_W  = 7
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  busy,
    output logic                  done,
    output logic [BIN_W-1:0]      bin_out,
    output logic                  err
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned REG_W = BCD_W + BIN_W;
    localparam int unsigned CNT_W = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0] LastStep = CNT_W'(BIN_W - 1);

    typedef enum logic [1:0] {
        StIdle,
        StConv,
        StFin
    } state_e;

    state_e             state_q, state_d;
    logic [REG_W-1:0]   work_q, work_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BIN_W-1:0]   bin_q, bin_d;
    logic               err_q, err_d;

    logic               bcd_invalid;
    logic               last_step;
    logic [REG_W-1:0]   shifted;
    logic [REG_W-1:0]   stepped;

    // Flag any operand nibble outside 0..9.
    always_comb begin
        bcd_invalid = 1'b0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (bcd_in[4*i +: 4] > 4'd9) begin
                bcd_invalid = 1'b1;
            end
        end
    end

    // One conversion step: shift right, then correct each digit that reached 8 or more.
    always_comb begin
        shifted = work_q >> 1;
        stepped = shifted;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (shifted[BIN_W + 4*i +: 4] >= 4'd8) begin
                stepped[BIN_W + 4*i +: 4] = shifted[BIN_W + 4*i +: 4] - 4'd3;
            end
        end
    end

    assign last_step = (cnt_q == LastStep);

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; invalid operands skip straight to FIN.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = bcd_invalid ? StFin : StConv;
                end
            end
            StConv: begin
                if (last_step) begin
                    state_d = StFin;
                end
            end
            StFin:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            StConv: busy = 1'b1;
            StFin: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath next-state: load on accepted start, step while converting.
    always_comb begin
        work_d = work_q;
        cnt_d  = cnt_q;
        bin_d  = bin_q;
        err_d  = err_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    err_d = bcd_invalid;
                    if (bcd_invalid) begin
                        bin_d = '0;
                    end else begin
                        work_d = {bcd_in, {BIN_W{1'b0}}};
                        cnt_d  = '0;
                    end
                end
            end
            StConv: begin
                work_d = stepped;
                cnt_d  = cnt_q + CNT_W'(1);
                if (last_step) begin
                    bin_d = stepped[BIN_W-1:0];
                end
            end
            default: ;
        endcase
    end

    // Datapath registers; reset discards any partial conversion.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            work_q <= '0;
            cnt_q  <= '0;
            bin_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            work_q <= work_d;
            cnt_q  <= cnt_d;
            bin_q  <= bin_d;
            err_q  <= err_d;
        end
    end

    assign bin_out = bin_q;
    assign err     = err_q;

`ifndef SYNTHESIS
    // The BCD field must have drained to zero once the final step lands.
    always_ff @(posedge clk) begin
        if (reset_n && (state_q == StConv) && last_step) begin
            assert (stepped[REG_W-1:BIN_W] == '0)
                else $error("bcd_to_bin_seq: bcd field not drained after last step");
        end
    end
`endif

endmodule
